// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder: issues imem requests for PC fetch addresses,
// tracks in-order outstanding responses in a slot ring and hands finished
// instructions to decode over valid/ready. A flush drops buffered slots and
// counts the still-owed responses so they can be discarded on arrival.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-PC error slots).
module instr_fetch_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        err;
`endif
    logic        done;
  } slot_t;

  slot_t         slots [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, discard;
  logic [AW+1:0] occ;
  logic          credit, aligned, alloc, deq;
  logic          rsp_hit;
  logic [AW-1:0] rsp_idx;
  logic [AW:0]   n_pend;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign aligned = (pc_i[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  // Credit covers both live slots and responses still owed from flushed fetches;
  // a dequeue only frees credit on the following cycle.
  assign occ    = {1'b0, count} + {1'b0, discard};
  assign credit = occ < (AW+2)'(FIFO_DEPTH);

  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign imem_req_o  = ~rst_i & pc_valid_i & credit & aligned & ~flush_i;
  // Misaligned fetches never touch memory, so they accept on credit alone.
  assign pc_ready_o  = aligned ? (imem_req_o & imem_gnt_i)
                               : (~rst_i & pc_valid_i & credit & ~flush_i);
  assign alloc = pc_ready_o;

  assign instr_valid_o = (count != '0) & slots[rd_ptr].done;
  assign instr_o       = slots[rd_ptr].data;
  assign instr_pc_o    = slots[rd_ptr].pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign instr_err_o   = slots[rd_ptr].err;
`else
  assign instr_err_o   = 1'b0;
`endif
  assign deq = instr_valid_o & instr_ready_i;

  // Find the oldest allocated not-done slot (response target) and count the
  // not-done slots; error slots are born done so they are skipped naturally.
  always_comb begin
    rsp_hit = 1'b0;
    rsp_idx = '0;
    n_pend  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (((AW+1)'(i) < count) && !slots[rd_ptr + AW'(i)].done) begin
        n_pend = n_pend + (AW+1)'(1);
        if (!rsp_hit) begin
          rsp_hit = 1'b1;
          rsp_idx = rd_ptr + AW'(i);
        end
      end
    end
  end

  // Slot ring, pointers, occupancy and discard bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      discard <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      discard <= discard + n_pend - (AW+1)'(imem_rvalid_i);
      for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
    end else begin
      if (alloc) begin
        slots[wr_ptr].pc   <= pc_i;
        slots[wr_ptr].data <= '0;
        slots[wr_ptr].done <= ~aligned;
`ifdef FETCH_MISALIGN_CHECK_EN
        slots[wr_ptr].err  <= ~aligned;
`endif
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (imem_rvalid_i) begin
        if (discard != '0) begin
          discard <= discard - (AW+1)'(1);
        end else if (rsp_hit) begin
          slots[rsp_idx].data <= imem_rdata_i;
          slots[rsp_idx].done <= 1'b1;
        end
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(alloc) - (AW+1)'(deq);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized-stall bench for instr_fetch_unit with a small
// in-order memory model driven from the same stimulus process.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;

  instr_fetch_unit #(.FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
    .flush_i(flush), .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata), .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready), .instr_o(instr), .instr_pc_o(instr_pc), .instr_err_o(instr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int gnt_pct = 100;
  int rv_pct = 100;
  bit rsp_hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h2408_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (p[1:0] != 2'b00) return 32'h0;
`endif
    return mem_word({p[31:2], 2'b00});
  endfunction

  function automatic logic exp_err(input logic [31:0] p);
`ifdef FETCH_MISALIGN_CHECK_EN
    return p[1:0] != 2'b00;
`else
    return 1'b0 & p[0];
`endif
  endfunction

  // Close the current cycle: record grant/response at the edge, then drive
  // the memory side for the next cycle. Returns at negedge+1.
  task automatic step();
    bit          took, popr;
    logic [31:0] a;
    took = imem_req && imem_gnt;
    popr = imem_rvalid;
    a    = imem_addr;
    @(posedge clk);
    if (popr && pend.size() > 0) void'(pend.pop_front());
    if (took) pend.push_back(a);
    @(negedge clk);
    imem_gnt = (gnt_pct >= 100) || ($urandom_range(99) < gnt_pct);
    if (!rsp_hold && pend.size() > 0 && ((rv_pct >= 100) || ($urandom_range(99) < rv_pct))) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0d want=0", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_out, cyc, pmax, cmax;
    logic [31:0] pcv;
    logic [1:0]  lowb;

    // reset
    pc = 32'h40; pc_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_pc_ready", pc_ready, 0);
    chk("rst_req", imem_req, 0);
    step(); step();
    rst = 1'b0; pc_valid = 1'b0; #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_err", instr_err, 0);
    chk("rst_count", 32'(dut.count), 0);
    step();

    // single aligned fetch: gnt N, rvalid N+1, valid N+2
    pc = 32'h40; pc_valid = 1'b1; instr_ready = 1'b0; #1;
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h40);
    chk("t1_pc_ready", pc_ready, 1);
    step();
    pc_valid = 1'b0; #1;
    chk("t1_valid_n1", instr_valid, 0);
    step();
    chk("t1_valid_n2", instr_valid, 1);
    chk("t1_instr", instr, 32'h2408_0005);
    chk("t1_pc", instr_pc, 32'h40);
    chk("t1_err", instr_err, 0);
    step();
    chk("t1_hold_valid", instr_valid, 1);
    chk("t1_hold_instr", instr, 32'h2408_0005);
    instr_ready = 1'b1; #1;
    step();
    chk("t1_drained", instr_valid, 0);

    // three requests with decode stalled: only two accepted
    instr_ready = 1'b0;
    pc = 32'h80; pc_valid = 1'b1; #1;
    chk("t2_acc0", pc_ready, 1);
    step();
    pc = 32'h84; #1;
    chk("t2_acc1", pc_ready, 1);
    step();
    pc = 32'h88; #1;
    chk("t2_full_ready", pc_ready, 0);
    chk("t2_full_req", imem_req, 0);
    step();
    instr_ready = 1'b1; #1;
    chk("t2_head_pc", instr_pc, 32'h80);
    chk("t2_head_data", instr, mem_word(32'h80));
    chk("t2_no_bypass", pc_ready, 0);
    step();
    chk("t2_third_acc", pc_ready, 1);
    chk("t2_second_pc", instr_pc, 32'h84);
    chk("t2_second_data", instr, mem_word(32'h84));
    step();
    pc_valid = 1'b0; #1;
    chk("t2_wait_third", instr_valid, 0);
    step();
    chk("t2_third_valid", instr_valid, 1);
    chk("t2_third_pc", instr_pc, 32'h88);
    chk("t2_third_data", instr, mem_word(32'h88));
    step();
    chk("t2_empty", instr_valid, 0);

    // misaligned fetch
    instr_ready = 1'b0;
    pc = 32'h42; pc_valid = 1'b1; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t3_no_req", imem_req, 0);
    chk("t3_acc", pc_ready, 1);
    step();
    pc_valid = 1'b0; #1;
    chk("t3_valid", instr_valid, 1);
    chk("t3_err", instr_err, 1);
    chk("t3_instr", instr, 0);
    chk("t3_pc", instr_pc, 32'h42);
`else
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h40);
    chk("t3_acc", pc_ready, 1);
    step();
    pc_valid = 1'b0; #1;
    step();
    chk("t3_valid", instr_valid, 1);
    chk("t3_err", instr_err, 0);
    chk("t3_instr", instr, 32'h2408_0005);
    chk("t3_pc", instr_pc, 32'h42);
`endif
    instr_ready = 1'b1; #1;
    step();
    chk("t3_empty", instr_valid, 0);

    // flush with two requests in flight
    rsp_hold = 1'b1;
    pc = 32'h200; pc_valid = 1'b1; #1;
    chk("t4_acc0", pc_ready, 1);
    step();
    pc = 32'h204; #1;
    chk("t4_acc1", pc_ready, 1);
    step();
    pc = 32'h100; flush = 1'b1; #1;
    chk("t4_flush_req", imem_req, 0);
    chk("t4_flush_ready", pc_ready, 0);
    rsp_hold = 1'b0;
    step();
    flush = 1'b0; #1;
    chk("t4_discard_full", pc_ready, 0);
    step();
    chk("t4_acc_new", pc_ready, 1);
    step();
    pc_valid = 1'b0; #1;
    chk("t4_not_yet", instr_valid, 0);
    step();
    chk("t4_valid", instr_valid, 1);
    chk("t4_pc", instr_pc, 32'h100);
    chk("t4_data", instr, mem_word(32'h100));
    step();
    chk("t4_empty", instr_valid, 0);
    chk("t4_discard", 32'(dut.discard), 0);

    // random stalls over 1000 fetches
    gnt_pct = 70; rv_pct = 60;
    pcv = 32'h1000; n_acc = 0; n_out = 0; cyc = 0; pmax = 0; cmax = 0;
    while (n_out < 1000 && cyc < 30000) begin
      pc = pcv;
      pc_valid = (n_acc < 1000) && ($urandom_range(3) != 0);
      instr_ready = ($urandom_range(3) != 0);
      #1;
      if (pc_valid && pc_ready) begin
        exp_q.push_back(pc);
        n_acc++;
        lowb = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
        pcv = {pcv[31:2] + 30'd1, lowb};
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_out", instr_pc, 32'hFFFF_FFFF);
        end else begin
          chk("rnd_pc", instr_pc, exp_q[0]);
          chk("rnd_data", instr, exp_data(exp_q[0]));
          chk("rnd_err", 32'(instr_err), 32'(exp_err(exp_q[0])));
          void'(exp_q.pop_front());
        end
        n_out++;
      end
      if (int'(dut.count) > cmax) cmax = int'(dut.count);
      step();
      cyc++;
      if (pend.size() > pmax) pmax = pend.size();
    end
    chk("rnd_outputs", n_out, 1000);
    pc_valid = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 200 && pend.size() > 0; k++) step();
    step();
    chk("rnd_exp_empty", exp_q.size(), 0);
    chk("rnd_pend_empty", pend.size(), 0);
    chk("rnd_discard", 32'(dut.discard), 0);
    chk("rnd_count", 32'(dut.count), 0);
    chk("rnd_outst_le_depth", 32'(pmax <= 2), 1);
    chk("rnd_count_le_depth", 32'(cmax <= 2), 1);

    // reset with two slots pending
    gnt_pct = 100; rv_pct = 100; instr_ready = 1'b0;
    pc = 32'h300; pc_valid = 1'b1; #1;
    step();
    pc = 32'h304; #1;
    step();
    chk("t6_valid_before", instr_valid, 1);
    rst = 1'b1; pc = 32'h308; #1;
    chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_ready", pc_ready, 0);
    pend.delete();
    step();
    rst = 1'b0; pc_valid = 1'b0; #1;
    chk("t6_valid", instr_valid, 0);
    chk("t6_instr", instr, 0);
    chk("t6_pc", instr_pc, 0);
    chk("t6_err", instr_err, 0);
    chk("t6_req", imem_req, 0);
    chk("t6_ready", pc_ready, 0);
    chk("t6_count", 32'(dut.count), 0);
    chk("t6_discard", 32'(dut.discard), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
